mynios2_tick_master: RTL and testbench
======================================

# mynios2_tick_master

Avalon-MM master that owns and services the system interval timer on the mynios2 fabric. It runs without the Nios II core: it programs the timer's control register, takes its interrupt, reads and clears the status register, and turns each timeout into a buffered tick handshake plus a free-running tick count. It is the initiator end of the timer's 16-bit register interface and connects to the timer slave either directly or through the interconnect.

## Interface
- READ_LATENCY, 1: cycles from an accepted read to valid m_readdata (1..4).
- PERIOD, 19'h7A11F: period value written when MYNIOS2_TICK_MASTER_PERIOD_RELOAD_EN is defined.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  level; 1 = timer serviced, 0 = interrupt disabled.
- m_address  out  3  word address (0 status, 1 control, 2 period_l, 3 period_h).
- m_chipselect  out  1  access request.
- m_write_n  out  1  0 = write, 1 = read while m_chipselect=1.
- m_writedata  out  16  write data.
- m_readdata  in  16  read data.
- m_waitrequest  in  1  stall; tie 0 when the slave is connected directly.
- irq  in  1  timer interrupt, level.
- tick_valid  out  1  a timeout is pending for the consumer.
- tick_ready  in  1  consumer accepts the tick.
- tick_count  out  32  serviced timeouts, wraps at 2^32.
- overrun_count  out  8  timeouts serviced while tick_valid was still high; saturates at 255.
- timer_running  out  1  RUN bit (bit 1) from the last status read.

## Operation
- States: IDLE, INIT_PL, INIT_PH, INIT_CTL, WAIT_IRQ, RD_REQ, RD_WAIT, CLR, DIS_CTL.
- IDLE: bus idle. When enable=1, go to INIT_PL if the macro is defined, otherwise to INIT_CTL.
- INIT_PL: write PERIOD[15:0] to address 2, then INIT_PH.
- INIT_PH: write {13'b0, PERIOD[18:16]} to address 3, then INIT_CTL.
- INIT_CTL: write 16'h0001 to address 1, then WAIT_IRQ.
- WAIT_IRQ:
  - enable=0 → DIS_CTL.
  - irq=1 → RD_REQ.
  - enable=0 takes priority over irq.
- RD_REQ: read address 0. Once accepted, go to RD_WAIT.
- RD_WAIT: count READ_LATENCY cycles, then sample m_readdata.
  - Load timer_running with bit 1.
  - Bit 0 = 1 → CLR.
  - Bit 0 = 0 (spurious interrupt) → WAIT_IRQ, with no write and no tick.
- CLR: write 16'h0000 to address 0. On acceptance:
  - tick_count increments.
  - tick_valid is set.
  - If tick_valid was already 1 and tick_ready=0 in that cycle, overrun_count increments.
  - Next state is WAIT_IRQ.
- DIS_CTL: write 16'h0000 to address 1, then IDLE.
- Every access holds address, data, chipselect and write_n stable while m_waitrequest=1. A transfer completes on the first cycle with m_chipselect=1 and m_waitrequest=0.
- Outside accesses: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
- tick_valid clears when tick_valid=1 and tick_ready=1. If that happens in the same cycle a CLR is accepted, tick_valid stays 1 and there is no overrun.
- enable changes during INIT/RD/CLR are ignored until WAIT_IRQ is reached. An interrupt that is in progress is always completed.
- Reset mid-operation: every register returns to its reset value immediately and any bus access is abandoned. The timer is not disabled, so its pending irq is serviced after re-initialisation.

## Timing
- Reset values:
  - m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
  - tick_valid=0, tick_count=0, overrun_count=0, timer_running=0.
  - State IDLE.
- All outputs are registered.
- With waitrequest=0 and READ_LATENCY=1, irq sampled high at edge E0 gives:
  - read presented in cycle E0..E1;
  - readdata sampled at E2;
  - clear write presented E2..E3, with tick_valid and tick_count updated at E3.
- The timer drops irq one cycle after the clear, so WAIT_IRQ never re-triggers on the same event.
- Each wait-state cycle adds exactly one cycle to the access that sees it.
- After enable rises (no macro), the control write is presented in the cycle after the edge that samples enable=1.

## Configuration
- MYNIOS2_TICK_MASTER_PERIOD_RELOAD_EN:
  - Defined: initialisation writes period_l and then period_h before control. The period write forces the timer to reload, which aligns the first tick to initialisation.
  - Undefined: INIT_PL and INIT_PH are not built. IDLE goes straight to INIT_CTL and the timer phase is free-running.

## Test plan
- Reset, enable=1, no macro → exactly one write, address 1 data 0001; the bus then idles in WAIT_IRQ.
- Macro defined → writes in order: address 2 data A11F, address 3 data 0007, address 1 data 0001.
- irq pulse, status read returns 0003, READ_LATENCY=1 → write address 0 data 0000 at E2; tick_count=1; tick_valid=1; timer_running=1.
- tick_ready held 0 over three serviced irqs → tick_count=3, overrun_count=2, tick_valid=1. Then tick_ready=1 for one cycle → tick_valid=0.
- Status read returns 0002 (spurious) → no clear write; tick_count unchanged.
- m_waitrequest=1 for 3 cycles on the clear → bus signals held stable for 4 cycles; tick is counted once. Then enable=0 → write address 1 data 0000 and return to IDLE.

Source files
------------

// File: rtl/mynios2_tick_master.sv
// Avalon-MM master that programs and services the interval timer, turning each timeout into a tick handshake.
// Optional build macro MYNIOS2_TICK_MASTER_PERIOD_RELOAD_EN adds period_l/period_h writes before the control write.
module mynios2_tick_master #(
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [18:0] PERIOD       = 19'h7A11F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [15:0] m_writedata,
    input  logic [15:0] m_readdata,
    input  logic        m_waitrequest,
    input  logic        irq,
    output logic        tick_valid,
    input  logic        tick_ready,
    output logic [31:0] tick_count,
    output logic [7:0]  overrun_count,
    output logic        timer_running,
    output logic [3:0]  dbg_state
);

    // Bus handshake: a transfer completes on the first edge with m_chipselect=1 and
    // m_waitrequest=0; until then address, data, chipselect and write_n are held.
    localparam logic [3:0] S_IDLE     = 4'd0;
`ifdef MYNIOS2_TICK_MASTER_PERIOD_RELOAD_EN
    localparam logic [3:0] S_INIT_PL  = 4'd1;
    localparam logic [3:0] S_INIT_PH  = 4'd2;
`endif
    localparam logic [3:0] S_INIT_CTL = 4'd3;
    localparam logic [3:0] S_WAIT_IRQ = 4'd4;
    localparam logic [3:0] S_RD_REQ   = 4'd5;
    localparam logic [3:0] S_RD_WAIT  = 4'd6;
    localparam logic [3:0] S_CLR      = 4'd7;
    localparam logic [3:0] S_DIS_CTL  = 4'd8;

    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    logic [3:0]  state_q, state_d;
    logic [1:0]  lat_q, lat_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        tick_valid_q, tick_valid_d;
    logic [31:0] tick_count_q, tick_count_d;
    logic [7:0]  overrun_q, overrun_d;
    logic        running_q, running_d;
    logic        accept;
    logic        unused_readdata;

    assign accept          = cs_q && !m_waitrequest;
    assign unused_readdata = ^m_readdata[15:2];

`ifndef MYNIOS2_TICK_MASTER_PERIOD_RELOAD_EN
    logic [18:0] unused_period;
    assign unused_period = PERIOD;
`endif

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        running_d    = running_q;
        tick_valid_d = tick_valid_q;
        tick_count_d = tick_count_q;
        overrun_d    = overrun_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
`ifdef MYNIOS2_TICK_MASTER_PERIOD_RELOAD_EN
                    state_d = S_INIT_PL;
`else
                    state_d = S_INIT_CTL;
`endif
                end
            end
`ifdef MYNIOS2_TICK_MASTER_PERIOD_RELOAD_EN
            S_INIT_PL:  if (accept) state_d = S_INIT_PH;
            S_INIT_PH:  if (accept) state_d = S_INIT_CTL;
`endif
            S_INIT_CTL: if (accept) state_d = S_WAIT_IRQ;
            S_WAIT_IRQ: begin
                if (!enable)  state_d = S_DIS_CTL;
                else if (irq) state_d = S_RD_REQ;
            end
            S_RD_REQ: begin
                if (accept) begin
                    state_d = S_RD_WAIT;
                    lat_d   = 2'd0;
                end
            end
            S_RD_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    running_d = m_readdata[1];
                    state_d   = m_readdata[0] ? S_CLR : S_WAIT_IRQ;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_CLR:      if (accept) state_d = S_WAIT_IRQ;
            S_DIS_CTL:  if (accept) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // A consumer pop in the same cycle as a new tick leaves tick_valid set with no overrun.
        if (state_q == S_CLR && accept) begin
            tick_valid_d = 1'b1;
            tick_count_d = tick_count_q + 32'd1;
            if (tick_valid_q && !tick_ready && overrun_q != 8'hFF)
                overrun_d = overrun_q + 8'd1;
        end else if (tick_valid_q && tick_ready) begin
            tick_valid_d = 1'b0;
        end
    end

    // Bus outputs are registered from the next state so they are stable for the whole access.
    always_comb begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = 3'd0;
        wdata_d = 16'h0000;
        case (state_d)
`ifdef MYNIOS2_TICK_MASTER_PERIOD_RELOAD_EN
            S_INIT_PL:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wdata_d = PERIOD[15:0]; end
            S_INIT_PH:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wdata_d = {13'b0, PERIOD[18:16]}; end
`endif
            S_INIT_CTL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0001; end
            S_RD_REQ:   begin cs_d = 1'b1; end
            S_CLR:      begin cs_d = 1'b1; wn_d = 1'b0; end
            S_DIS_CTL:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            lat_q        <= 2'd0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            addr_q       <= 3'd0;
            wdata_q      <= 16'h0000;
            tick_valid_q <= 1'b0;
            tick_count_q <= 32'd0;
            overrun_q    <= 8'd0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            tick_valid_q <= tick_valid_d;
            tick_count_q <= tick_count_d;
            overrun_q    <= overrun_d;
            running_q    <= running_d;
        end
    end

    assign m_chipselect  = cs_q;
    assign m_write_n     = wn_q;
    assign m_address     = addr_q;
    assign m_writedata   = wdata_q;
    assign tick_valid    = tick_valid_q;
    assign tick_count    = tick_count_q;
    assign overrun_count = overrun_q;
    assign timer_running = running_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mynios2_tick_master.sv
// Bench for mynios2_tick_master: timer-slave model with a transfer scoreboard, a table of irq scenarios,
// and hand sequences for overrun saturation, wait states, disable and reset mid-operation.
module tb_mynios2_tick_master;

    localparam int unsigned READ_LATENCY = 1;
    localparam logic [15:0] GARBAGE  = 16'hFFFC;
    localparam logic [3:0]  ST_IDLE  = 4'd0;
    localparam logic [3:0]  ST_WAIT  = 4'd4;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [2:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [15:0] m_writedata;
    logic [15:0] m_readdata;
    logic        m_waitrequest;
    logic        irq;
    logic        tick_valid;
    logic        tick_ready;
    logic [31:0] tick_count;
    logic [7:0]  overrun_count;
    logic        timer_running;
    logic [3:0]  dbg_state;

    mynios2_tick_master #(.READ_LATENCY(READ_LATENCY)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .irq(irq), .tick_valid(tick_valid), .tick_ready(tick_ready), .tick_count(tick_count),
        .overrun_count(overrun_count), .timer_running(timer_running), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [19:0] exp_q[$];   // {write_n, address, writedata}; data is 0 for reads
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timer slave model ----------------
    logic [15:0] status_val = 16'h0000;
    int          irq_raise_cnt = 0;
    int          stall_clr_cycles = 0;
    int          last_clr_len = 0;

    initial begin : slave
        int          irq_seen;
        int          rd_pend;
        int          run_stall;
        int          clr_len;
        bit          drop_next;
        bit          prev_stalled;
        bit          is_clr;
        logic [20:0] cur;
        logic [20:0] prev_bus;
        logic [19:0] got;
        logic [19:0] want;
        irq_seen = 0; rd_pend = 0; run_stall = 0; clr_len = 0;
        drop_next = 0; prev_stalled = 0; prev_bus = '0;
        m_readdata = GARBAGE; m_waitrequest = 1'b0; irq = 1'b0;
        forever begin
            @(negedge clk);
            if (drop_next) begin irq = 1'b0; drop_next = 0; end
            if (irq_seen != irq_raise_cnt) begin irq = 1'b1; irq_seen = irq_raise_cnt; end
            if (!reset_n) begin
                rd_pend = 0; run_stall = 0; clr_len = 0; prev_stalled = 0;
                m_waitrequest = 1'b0; m_readdata = GARBAGE;
                continue;
            end
            if (rd_pend > 0) begin
                rd_pend--;
                m_readdata = (rd_pend == 0) ? status_val : GARBAGE;
            end else begin
                m_readdata = GARBAGE;
            end
            cur = {m_chipselect, m_write_n, m_address, m_writedata};
            if (prev_stalled) chk("bus_hold", 32'(cur), 32'(prev_bus));
            if (!m_chipselect) begin
                chk("idle_bus", 32'({m_write_n, m_address, m_writedata}), 32'({1'b1, 3'd0, 16'h0}));
                run_stall = 0;
                clr_len = 0;
            end
            is_clr = m_chipselect && !m_write_n && m_address == 3'd0;
            if (is_clr) clr_len++;
            if (is_clr && run_stall < stall_clr_cycles) begin
                m_waitrequest = 1'b1;
                run_stall++;
            end else begin
                m_waitrequest = 1'b0;
            end
            if (m_chipselect && !m_waitrequest) begin
                got = {m_write_n, m_address, m_write_n ? 16'h0 : m_writedata};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL xfer_unexpected: got %0h required none at %0t", got, $time);
                end else begin
                    want = exp_q.pop_front();
                    chk("xfer", 32'(got), 32'(want));
                end
                if (is_clr) begin
                    last_clr_len = clr_len;
                    clr_len = 0;
                    drop_next = 1;
                end
                if (m_write_n) begin
                    rd_pend = READ_LATENCY;
                    if (!status_val[0]) drop_next = 1;
                end
                run_stall = 0;
                prev_stalled = 0;
            end else begin
                prev_stalled = m_chipselect;
            end
            prev_bus = cur;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_init();
`ifdef MYNIOS2_TICK_MASTER_PERIOD_RELOAD_EN
        exp_q.push_back({1'b0, 3'd2, 16'hA11F});
        exp_q.push_back({1'b0, 3'd3, 16'h0007});
`endif
        exp_q.push_back({1'b0, 3'd1, 16'h0001});
    endtask

    task automatic wait_state(input logic [3:0] st, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (dbg_state == st) hit = 1;
        end
        chk(name, 32'(hit), 32'd1);
    endtask

    // Raise irq with the given status; if it is a real timeout, hold tick_ready=rdy_clr
    // only while the clear write is on the bus. Returns one cycle after the clear completes.
    task automatic service(input logic [15:0] status, input logic rdy_clr);
        bit presented;
        bit done;
        status_val = status;
        exp_q.push_back({1'b1, 3'd0, 16'h0});
        if (status[0]) exp_q.push_back({1'b0, 3'd0, 16'h0});
        irq_raise_cnt++;
        if (status[0]) begin
            presented = 0;
            done = 0;
            for (int i = 0; i < 30 && !done; i++) begin
                step();
                if (m_chipselect && !m_write_n && m_address == 3'd0) begin
                    presented = 1;
                    tick_ready = rdy_clr;
                end else if (presented) begin
                    done = 1;
                end
            end
            tick_ready = 1'b0;
            chk("clear_done", 32'(done), 32'd1);
        end else begin
            repeat (6) step();
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [15:0] status;
        logic        rdy_clr;
        logic        pulse_before;
        logic [31:0] exp_count;
        logic [7:0]  exp_over;
        logic        exp_valid;
        logic        exp_running;
    } vec_t;

    vec_t vecs[7];

    initial begin : test
        logic [31:0] e_count;
        logic [7:0]  e_over;
        logic        e_run;
        logic [15:0] st;
        bit          hit;

        vecs[0] = '{16'h0003, 1'b0, 1'b0, 32'd1, 8'd0, 1'b1, 1'b1};
        vecs[1] = '{16'h0003, 1'b0, 1'b0, 32'd2, 8'd1, 1'b1, 1'b1};
        vecs[2] = '{16'h0003, 1'b0, 1'b0, 32'd3, 8'd2, 1'b1, 1'b1};
        vecs[3] = '{16'h0002, 1'b0, 1'b1, 32'd3, 8'd2, 1'b0, 1'b1};
        vecs[4] = '{16'h0001, 1'b0, 1'b0, 32'd4, 8'd2, 1'b1, 1'b0};
        vecs[5] = '{16'h0001, 1'b1, 1'b0, 32'd5, 8'd2, 1'b1, 1'b0};
        vecs[6] = '{16'h0003, 1'b0, 1'b0, 32'd6, 8'd3, 1'b1, 1'b1};

        reset_n = 1'b0; enable = 1'b0; tick_ready = 1'b0;
        repeat (3) step();
        chk("rst_cs", 32'(m_chipselect), 32'd0);
        chk("rst_write_n", 32'(m_write_n), 32'd1);
        chk("rst_addr", 32'(m_address), 32'd0);
        chk("rst_wdata", 32'(m_writedata), 32'd0);
        chk("rst_tick_valid", 32'(tick_valid), 32'd0);
        chk("rst_tick_count", tick_count, 32'd0);
        chk("rst_overrun", 32'(overrun_count), 32'd0);
        chk("rst_running", 32'(timer_running), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        reset_n = 1'b1;
        repeat (2) step();
        chk("idle_no_enable", 32'(m_chipselect), 32'd0);
        push_init();
        enable = 1'b1;
        step();
        chk("first_write_cs", 32'(m_chipselect), 32'd1);
`ifdef MYNIOS2_TICK_MASTER_PERIOD_RELOAD_EN
        chk("first_write_addr", 32'(m_address), 32'd2);
`else
        chk("first_write_addr", 32'(m_address), 32'd1);
`endif
        wait_state(ST_WAIT, "init_done");
        repeat (4) step();
        chk("init_writes_drained", exp_q.size(), 32'd0);
        chk("wait_irq_idle", 32'(dbg_state), 32'(ST_WAIT));

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].pulse_before) begin
                tick_ready = 1'b1;
                step();
                tick_ready = 1'b0;
                chk("ready_pulse_valid", 32'(tick_valid), 32'd0);
            end
            service(vecs[i].status, vecs[i].rdy_clr);
            chk($sformatf("v%0d_count", i), tick_count, vecs[i].exp_count);
            chk($sformatf("v%0d_overrun", i), 32'(overrun_count), 32'(vecs[i].exp_over));
            chk($sformatf("v%0d_valid", i), 32'(tick_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_running", i), 32'(timer_running), 32'(vecs[i].exp_running));
        end

        // Overrun saturation with random RUN bits.
        e_count = 32'd6; e_over = 8'd3; e_run = 1'b1;
        for (int i = 0; i < 260; i++) begin
            st = {14'b0, 1'($urandom_range(0, 1)), 1'b1};
            service(st, 1'b0);
            e_count++;
            if (e_over != 8'hFF) e_over++;
            e_run = st[1];
        end
        chk("sat_count", tick_count, e_count);
        chk("sat_overrun", 32'(overrun_count), 32'd255);
        chk("sat_running", 32'(timer_running), 32'(e_run));

        // Three wait states on the clear write.
        stall_clr_cycles = 3;
        service(16'h0003, 1'b0);
        stall_clr_cycles = 0;
        e_count++;
        chk("stall_clr_len", last_clr_len, 32'd4);
        chk("stall_count", tick_count, e_count);
        chk("stall_overrun", 32'(overrun_count), 32'd255);

        // Disable: control cleared, back to IDLE.
        exp_q.push_back({1'b0, 3'd1, 16'h0000});
        enable = 1'b0;
        wait_state(ST_IDLE, "disable_idle");
        repeat (3) step();
        chk("disable_drained", exp_q.size(), 32'd0);
        chk("disable_keeps_count", tick_count, e_count);

        // Reset in the middle of a stalled clear; the pending irq is serviced after re-init.
        push_init();
        enable = 1'b1;
        wait_state(ST_WAIT, "reinit_done");
        stall_clr_cycles = 100;
        status_val = 16'h0003;
        exp_q.push_back({1'b1, 3'd0, 16'h0});
        exp_q.push_back({1'b0, 3'd0, 16'h0});
        irq_raise_cnt++;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (m_chipselect && !m_write_n && m_address == 3'd0) hit = 1;
        end
        chk("midop_clear_seen", 32'(hit), 32'd1);
        step();
        chk("midop_running", 32'(timer_running), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midop_rst_cs", 32'(m_chipselect), 32'd0);
        chk("midop_rst_count", tick_count, 32'd0);
        chk("midop_rst_overrun", 32'(overrun_count), 32'd0);
        chk("midop_rst_valid", 32'(tick_valid), 32'd0);
        chk("midop_rst_running", 32'(timer_running), 32'd0);
        chk("midop_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        stall_clr_cycles = 0;
        push_init();
        exp_q.push_back({1'b1, 3'd0, 16'h0});
        exp_q.push_back({1'b0, 3'd0, 16'h0});
        step();
        step();
        reset_n = 1'b1;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            if (tick_count == 32'd1) hit = 1;
        end
        chk("post_reset_tick", 32'(hit), 32'd1);
        chk("post_reset_valid", 32'(tick_valid), 32'd1);
        chk("post_reset_running", 32'(timer_running), 32'd1);
        repeat (5) step();
        chk("post_reset_count_stable", tick_count, 32'd1);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
